// File: rtl/hdmi_packet_scheduler.sv
// hdmi_packet_scheduler
//   Per-frame HDMI data-island packet scheduler with an integrated audio sample FIFO.
//   Frame order: ACR (0x01), optional AVI InfoFrame (0x82), Audio InfoFrame (0x84),
//   then audio sample packets (0x02, up to 4 samples each); null (0x00) when idle.
//
//   Optional feature macro: HDMI_PKT_SCHED_AVI_EN
//     defined     -> AVI InfoFrame slot (0x82) emitted after ACR
//     not defined -> ACR goes straight to Audio InfoFrame, 0x82 never emitted
//
// Ports
//   clk_pixel         in   pixel clock, all logic on posedge
//   reset             in   synchronous, active-high
//   frame_start       in   1-cycle pulse at pixel (0,0), restarts the frame order
//   packet_enable     in   1-cycle pulse, hdmi core latches the next packet
//   sample_valid      in   push strobe for sample_in
//   sample_in         in   {ch[CHANNELS-1]..ch0}, AUDIO_BIT_WIDTH bits per channel
//   packet_type       out  header type of the current packet slot
//   audio_sample_word out  slot s, channel c at [(2s+c)*W +: W]
//   sample_present    out  bit s set when slot s carries a valid sample
//   fifo_level        out  entries currently buffered
//   overflow          out  sticky, a sample was dropped (cleared only by reset)
module hdmi_packet_scheduler #(
  parameter int unsigned AUDIO_BIT_WIDTH = 16,
  parameter int unsigned CHANNELS        = 2,
  parameter int unsigned FIFO_DEPTH      = 16
) (
  input  logic                             clk_pixel,
  input  logic                             reset,
  input  logic                             frame_start,
  input  logic                             packet_enable,
  input  logic                             sample_valid,
  input  logic [CHANNELS*AUDIO_BIT_WIDTH-1:0] sample_in,
  output logic [7:0]                       packet_type,
  output logic [8*AUDIO_BIT_WIDTH-1:0]     audio_sample_word,
  output logic [3:0]                       sample_present,
  output logic [$clog2(FIFO_DEPTH):0]      fifo_level,
  output logic                             overflow
);

  localparam int unsigned W  = AUDIO_BIT_WIDTH;
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = PW + 1;

`ifdef HDMI_PKT_SCHED_AVI_EN
  typedef enum logic [1:0] {
    StAcr     = 2'd0,
    StAvi     = 2'd1,
    StAif     = 2'd2,
    StSamples = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    StAcr     = 2'd0,
    StAif     = 2'd2,
    StSamples = 2'd3
  } state_e;
`endif

  state_e state_q, eff_state, state_next;

  logic [2*W-1:0]  mem [FIFO_DEPTH];
  logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [LW-1:0]   level_q;
  logic [2*W-1:0]  entry;
  logic [2:0]      pop_n;
  logic            push_ok;
  logic [7:0]      type_d;
  logic [8*W-1:0]  word_d;
  logic [3:0]      present_d;

  // Each FIFO entry is {R, L}; mono input is duplicated into both channels.
  if (CHANNELS == 1) begin : g_mono
    assign entry = {sample_in[W-1:0], sample_in[W-1:0]};
  end else begin : g_stereo
    assign entry = sample_in[2*W-1:0];
  end

  always_comb begin
    // frame_start overrides the current state, even when packet_enable arrives with it
    eff_state = frame_start ? StAcr : state_q;

    pop_n = 3'd0;
    if (packet_enable && eff_state == StSamples) begin
      pop_n = (level_q >= LW'(4)) ? 3'd4 : level_q[2:0];
    end

    // Pop is applied first, so a full FIFO still accepts a push in a popping cycle
    push_ok = sample_valid && ((level_q - LW'(pop_n)) < LW'(FIFO_DEPTH));

    word_d = '0;
    for (int s = 0; s < 4; s++) begin
      if (3'(s) < pop_n) begin
        word_d[s*2*W +: 2*W] = mem[rd_ptr_q + PW'(s)];
      end
    end
    present_d = 4'((5'd1 << pop_n) - 5'd1);

    type_d     = 8'h00;
    state_next = eff_state;
    case (eff_state)
      StAcr: begin
        type_d = 8'h01;
`ifdef HDMI_PKT_SCHED_AVI_EN
        state_next = StAvi;
`else
        state_next = StAif;
`endif
      end
`ifdef HDMI_PKT_SCHED_AVI_EN
      StAvi: begin
        type_d     = 8'h82;
        state_next = StAif;
      end
`endif
      StAif: begin
        type_d     = 8'h84;
        state_next = StSamples;
      end
      StSamples: begin
        type_d     = (pop_n != 3'd0) ? 8'h02 : 8'h00;
        state_next = StSamples;
      end
      default: begin
        type_d     = 8'h00;
        state_next = StAcr;
      end
    endcase
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state_q           <= StAcr;
      packet_type       <= 8'h00;
      audio_sample_word <= '0;
      sample_present    <= 4'h0;
      rd_ptr_q          <= '0;
      wr_ptr_q          <= '0;
      level_q           <= '0;
      overflow          <= 1'b0;
    end else begin
      if (packet_enable) begin
        state_q           <= state_next;
        packet_type       <= type_d;
        audio_sample_word <= word_d;
        sample_present    <= present_d;
      end else if (frame_start) begin
        state_q <= StAcr;
      end
      rd_ptr_q <= rd_ptr_q + PW'(pop_n);
      wr_ptr_q <= wr_ptr_q + PW'(push_ok);
      level_q  <= level_q - LW'(pop_n) + LW'(push_ok);
      if (sample_valid && !push_ok) begin
        overflow <= 1'b1;
      end
    end
  end

  // Sample storage carries no reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk_pixel) begin
    if (!reset && push_ok) begin
      mem[wr_ptr_q] <= entry;
    end
  end

  assign fifo_level = level_q;

endmodule

// File: tb/tb_hdmi_packet_scheduler.sv
module tb_hdmi_packet_scheduler;

  logic         clk_pixel = 1'b0;
  logic         reset = 1'b1;
  logic         frame_start = 1'b0;
  logic         packet_enable = 1'b0;
  logic         sample_valid = 1'b0;
  logic [31:0]  sample_in = '0;
  logic [7:0]   packet_type;
  logic [127:0] audio_sample_word;
  logic [3:0]   sample_present;
  logic [4:0]   fifo_level;
  logic         overflow;

  logic         m_valid = 1'b0;
  logic [15:0]  m_in = '0;
  logic [7:0]   m_type;
  logic [127:0] m_word;
  logic [3:0]   m_present;
  logic [4:0]   m_level;
  logic         m_overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk_pixel = ~clk_pixel;

  hdmi_packet_scheduler #(
    .AUDIO_BIT_WIDTH(16),
    .CHANNELS       (2),
    .FIFO_DEPTH     (16)
  ) dut (
    .clk_pixel        (clk_pixel),
    .reset            (reset),
    .frame_start      (frame_start),
    .packet_enable    (packet_enable),
    .sample_valid     (sample_valid),
    .sample_in        (sample_in),
    .packet_type      (packet_type),
    .audio_sample_word(audio_sample_word),
    .sample_present   (sample_present),
    .fifo_level       (fifo_level),
    .overflow         (overflow)
  );

  hdmi_packet_scheduler #(
    .AUDIO_BIT_WIDTH(16),
    .CHANNELS       (1),
    .FIFO_DEPTH     (16)
  ) dut_mono (
    .clk_pixel        (clk_pixel),
    .reset            (reset),
    .frame_start      (frame_start),
    .packet_enable    (packet_enable),
    .sample_valid     (m_valid),
    .sample_in        (m_in),
    .packet_type      (m_type),
    .audio_sample_word(m_word),
    .sample_present   (m_present),
    .fifo_level       (m_level),
    .overflow         (m_overflow)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are read there too.
  task automatic tick();
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic pulse_pe();
    packet_enable = 1'b1;
    tick();
    packet_enable = 1'b0;
  endtask

  // Slots s < n hold L = lbase+s, R = rbase+s; the rest are zero.
  function automatic logic [127:0] mk_word(input int n, input logic [15:0] lbase,
                                           input logic [15:0] rbase);
    logic [127:0] w;
    w = '0;
    for (int s = 0; s < n; s++) begin
      w[(2*s)*16 +: 16]   = lbase + 16'(s);
      w[(2*s+1)*16 +: 16] = rbase + 16'(s);
    end
    return w;
  endfunction

  initial begin
    logic [7:0] exp_types [4];
`ifdef HDMI_PKT_SCHED_AVI_EN
    exp_types = '{8'h01, 8'h82, 8'h84, 8'h00};
`else
    exp_types = '{8'h01, 8'h84, 8'h00, 8'h00};
`endif

    // Reset state
    #1;
    tick();
    reset = 1'b0;
    tick();
    check_eq("rst_type", 128'(packet_type), 128'h0);
    check_eq("rst_word", audio_sample_word, 128'h0);
    check_eq("rst_present", 128'(sample_present), 128'h0);
    check_eq("rst_level", 128'(fifo_level), 128'h0);
    check_eq("rst_overflow", 128'(overflow), 128'h0);

    // Frame order with an empty FIFO
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pulse_pe();
      check_eq($sformatf("order_type%0d", i), 128'(packet_type), 128'(exp_types[i]));
    end
    check_eq("null_present", 128'(sample_present), 128'h0);

    // Six stereo samples; one mono sample on the mono instance
    for (int i = 0; i < 6; i++) begin
      sample_valid = 1'b1;
      sample_in    = {16'h2000 + 16'(i), 16'h1000 + 16'(i)};
      m_valid      = (i == 0);
      m_in         = 16'hABCD;
      tick();
    end
    sample_valid = 1'b0;
    m_valid      = 1'b0;
    check_eq("push6_level", 128'(fifo_level), 128'd6);

    pulse_pe();
    check_eq("pkt1_type", 128'(packet_type), 128'h02);
    check_eq("pkt1_present", 128'(sample_present), 128'hF);
    check_eq("pkt1_word", audio_sample_word, mk_word(4, 16'h1000, 16'h2000));
    check_eq("pkt1_level", 128'(fifo_level), 128'd2);
    check_eq("mono_type", 128'(m_type), 128'h02);
    check_eq("mono_present", 128'(m_present), 128'h1);
    check_eq("mono_word", m_word, 128'hABCD_ABCD);

    tick();
    check_eq("hold_present", 128'(sample_present), 128'hF);

    pulse_pe();
    check_eq("pkt2_type", 128'(packet_type), 128'h02);
    check_eq("pkt2_present", 128'(sample_present), 128'h3);
    check_eq("pkt2_word", audio_sample_word, mk_word(2, 16'h1004, 16'h2004));
    check_eq("pkt2_level", 128'(fifo_level), 128'd0);

    pulse_pe();
    check_eq("empty_type", 128'(packet_type), 128'h00);
    check_eq("empty_word", audio_sample_word, 128'h0);
    check_eq("pre_ovf", 128'(overflow), 128'h0);

    // Fill past capacity with no pops; the 17th sample is dropped
    for (int i = 0; i < 17; i++) begin
      sample_valid = 1'b1;
      sample_in    = {16'h6000 + 16'(i), 16'h5000 + 16'(i)};
      tick();
    end
    sample_valid = 1'b0;
    check_eq("full_level", 128'(fifo_level), 128'd16);
    check_eq("full_ovf", 128'(overflow), 128'h1);

    // Push into a full FIFO in a popping cycle is accepted
    sample_valid = 1'b1;
    sample_in    = {16'h6011, 16'h5011};
    packet_enable = 1'b1;
    tick();
    sample_valid  = 1'b0;
    packet_enable = 1'b0;
    check_eq("pushpop_level", 128'(fifo_level), 128'd13);
    check_eq("pushpop_present", 128'(sample_present), 128'hF);
    check_eq("pushpop_word", audio_sample_word, mk_word(4, 16'h5000, 16'h6000));

    // frame_start beats packet_enable in the same cycle
    frame_start   = 1'b1;
    packet_enable = 1'b1;
    tick();
    frame_start   = 1'b0;
    packet_enable = 1'b0;
    check_eq("fs_pe_type", 128'(packet_type), 128'h01);
    check_eq("fs_pe_present", 128'(sample_present), 128'h0);
    check_eq("fs_pe_level", 128'(fifo_level), 128'd13);
    pulse_pe();
    check_eq("after_acr_type", 128'(packet_type), 128'(exp_types[1]));

    // Reset mid-stream discards buffered samples
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("mid_rst_type", 128'(packet_type), 128'h0);
    check_eq("mid_rst_word", audio_sample_word, 128'h0);
    check_eq("mid_rst_level", 128'(fifo_level), 128'h0);
    check_eq("mid_rst_ovf", 128'(overflow), 128'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
